control_unit: RTL and testbench

Multicycle CPU control FSM: the initiator side of the ALU interface. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the ALU op code plus every datapath mux and enable. It also consumes the ALU `zero` flag to resolve branches. It sits beside the datapath: the IR feeds it the opcode, and its outputs steer PC, memory, register file and ALU.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/control_unit.sv | 124 ++++++++++++
 tb/tb_control_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU op, mux select and control-state definitions for the multicycle CPU.
package cpu_pkg;
  localparam logic [3:0] OP_LW      = 4'b1000;
  localparam logic [3:0] OP_SW      = 4'b1001;
  localparam logic [3:0] OP_BEQ     = 4'b1010;
  localparam logic [3:0] OP_J       = 4'b1011;
  localparam logic [3:0] OP_HALT    = 4'b1111;
  localparam logic [3:0] OP_ILL_R   = 4'b0111;
  localparam logic [2:0] ALU_MOV    = 3'b000;
  localparam logic [2:0] ALU_NOT    = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b100;
  localparam logic [2:0] ALU_AND    = 3'b101;
  localparam logic [2:0] ALU_SLT    = 3'b110;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXECUTE   = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       halted;
  } ctrl_t;
  function automatic logic is_rtype(input logic [3:0] op);
    return !op[3] && op != OP_ILL_R;
  endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: multicycle CPU control FSM driving ALU op, datapath muxes and enables.
// Ports: clk, reset (sync, active-high), opcode (IR[31:28]), zero (ALU flag) in;
// alu_op, alu_src_a, alu_src_b, pc_source, pc_en, ior_d, mem_read, mem_write,
// ir_write, reg_write, mem_to_reg, reg_dst, halted, state (debug) out.
module control_unit
  import cpu_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic               zero,
  output logic [2:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               ior_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               halted,
  output logic [STATE_W-1:0] state
);
  state_t state_q, state_d;
  ctrl_t  raw, ctl;
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = is_rtype(opcode) ? S_EXECUTE :
                             (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                             opcode == OP_BEQ  ? S_BRANCH :
                             opcode == OP_J    ? S_JUMP :
                             opcode == OP_HALT ? S_HALT : S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_MEM_ADDR:  state_d = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end
  always_comb begin
    raw = '0;
    case (state_q)
      S_FETCH: begin
        raw.mem_read  = 1'b1;
        raw.ir_write  = 1'b1;
        raw.alu_src_b = SRC_B_FOUR;
        raw.alu_op    = ALU_ADD;
        raw.pc_source = PC_ALU;
        raw.pc_write  = 1'b1;
      end
      S_DECODE: begin
        raw.alu_src_b = SRC_B_IMM2;
        raw.alu_op    = ALU_ADD;
      end
      S_EXECUTE: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRC_B_REG;
        raw.alu_op    = opcode[2:0];
      end
      S_ALU_WB: begin
        raw.reg_write = 1'b1;
        raw.reg_dst   = 1'b1;
      end
      S_MEM_ADDR: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRC_B_IMM;
        raw.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        raw.mem_read = 1'b1;
        raw.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        raw.reg_write  = 1'b1;
        raw.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        raw.mem_write = 1'b1;
        raw.ior_d     = 1'b1;
      end
      S_BRANCH: begin
        raw.alu_src_a     = 1'b1;
        raw.alu_src_b     = SRC_B_REG;
        raw.alu_op        = ALU_SUB;
        raw.pc_write_cond = 1'b1;
        raw.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        raw.pc_write  = 1'b1;
        raw.pc_source = PC_JUMP;
      end
      S_HALT:  raw.halted = 1'b1;
      default: raw = '0;
    endcase
  end
  // Reset gates every output combinationally so an aborted instruction can
  // never assert an enable in a cycle where reset is high.
  assign ctl        = reset ? '0 : raw;
  assign alu_op     = ctl.alu_op;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign pc_source  = ctl.pc_source;
  assign pc_en      = ctl.pc_write | (ctl.pc_write_cond & zero);
  assign ior_d      = ctl.ior_d;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign ir_write   = ctl.ir_write;
  assign reg_write  = ctl.reg_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_dst    = ctl.reg_dst;
  assign halted     = ctl.halted;
  assign state      = reset ? '0 : STATE_W'(state_q);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: checks control_unit against an instruction-path model plus directed literal expectations.
module tb_control_unit;
  import cpu_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zero = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en, ior_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg, reg_dst, halted;
  logic [3:0] state;
  int errors = 0;
  int checks = 0;
  control_unit #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .pc_en(pc_en), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  wire [16:0] dut_vec = {alu_op, alu_src_a, alu_src_b, pc_source, pc_en, ior_d, mem_read,
                         mem_write, ir_write, reg_write, mem_to_reg, reg_dst, halted};
  state_t m_state = S_FETCH;
  state_t path [3];
  int     plen = 0;
  int     pidx = 0;
  bit     m_valid = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      m_state = S_FETCH;
      plen = 0;
      pidx = 0;
      m_valid = 1'b1;
    end else if (m_valid && m_state != S_HALT) begin
      if (m_state == S_FETCH) m_state = S_DECODE;
      else begin
        if (m_state == S_DECODE) begin
          pidx = 0;
          plen = 0;
          if (opcode <= 4'd6) begin path[0] = S_EXECUTE; path[1] = S_ALU_WB; plen = 2; end
          else if (opcode == 4'd8) begin path[0] = S_MEM_ADDR; path[1] = S_MEM_READ; path[2] = S_MEM_WB; plen = 3; end
          else if (opcode == 4'd9) begin path[0] = S_MEM_ADDR; path[1] = S_MEM_WRITE; plen = 2; end
          else if (opcode == 4'd10) begin path[0] = S_BRANCH; plen = 1; end
          else if (opcode == 4'd11) begin path[0] = S_JUMP; plen = 1; end
          else if (opcode == 4'd15) begin path[0] = S_HALT; plen = 1; end
        end
        m_state = pidx < plen ? path[pidx] : S_FETCH;
        pidx++;
      end
    end
  end
  function automatic logic [16:0] expect_out(input state_t s, input logic [3:0] op, input logic z);
    logic [2:0] a; logic sa; logic [1:0] sb, ps;
    logic pe, io, mr, mw, iw, rw, m2r, rd, h;
    {a, sa, sb, ps, pe, io, mr, mw, iw, rw, m2r, rd, h} = '0;
    case (s)
      S_FETCH:     begin mr = 1; iw = 1; sb = 2'b01; a = 3'b010; pe = 1; end
      S_DECODE:    begin sb = 2'b11; a = 3'b010; end
      S_EXECUTE:   begin sa = 1; a = op[2:0]; end
      S_ALU_WB:    begin rw = 1; rd = 1; end
      S_MEM_ADDR:  begin sa = 1; sb = 2'b10; a = 3'b010; end
      S_MEM_READ:  begin mr = 1; io = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: begin mw = 1; io = 1; end
      S_BRANCH:    begin sa = 1; a = 3'b011; ps = 2'b01; pe = z; end
      S_JUMP:      begin ps = 2'b10; pe = 1; end
      S_HALT:      h = 1;
      default:     h = 0;
    endcase
    return {a, sa, sb, ps, pe, io, mr, mw, iw, rw, m2r, rd, h};
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ({dut_vec, state} != 21'd0) begin
        errors++;
        $display("FAIL reset_zero: outputs=%h state=%0d required all zero", dut_vec, state);
      end
    end else if (m_valid) begin
      checks++;
      if (dut_vec != expect_out(m_state, opcode, zero)) begin
        errors++;
        $display("FAIL model_outputs t=%0t: got=%b expected=%b (state %0d)", $time, dut_vec, expect_out(m_state, opcode, zero), m_state);
      end
      checks++;
      if (state != m_state) begin
        errors++;
        $display("FAIL model_state t=%0t: got=%0d expected=%0d", $time, state, m_state);
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask
  int lat, mw_n, rw_n, pe_x, mrio_n, m2r_n, ex_op, nxt;
  task automatic instr(input logic [3:0] op, input logic z);
    opcode = op;
    zero = z;
    lat = 1; mw_n = 0; rw_n = 0; pe_x = 0; mrio_n = 0; m2r_n = 0; ex_op = -1; nxt = -1;
    forever begin
      @(posedge clk);
      #1;
      if (nxt < 0) nxt = int'(state);
      if (state == 4'(S_FETCH)) break;
      lat++;
      mw_n += int'(mem_write);
      rw_n += int'(reg_write);
      pe_x += int'(pc_en);
      mrio_n += int'(mem_read & ior_d);
      m2r_n += int'(mem_to_reg);
      if (state == 4'(S_EXECUTE)) ex_op = int'(alu_op);
      if (lat > 20) begin
        errors++;
        $display("FAIL timeout: op=%b never returned to FETCH", op);
        break;
      end
    end
  endtask
  initial begin
    @(negedge clk);
    chk("reset_mem_read", int'(mem_read), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("fetch_mem_read", int'(mem_read), 1);
    chk("fetch_ir_write", int'(ir_write), 1);
    chk("fetch_pc_en", int'(pc_en), 1);
    chk("fetch_alu_op", int'(alu_op), 2);
    instr(4'b0011, 1'b0);
    chk("sub_next_decode", nxt, int'(S_DECODE));
    chk("sub_latency", lat, 4);
    chk("sub_exec_alu_op", ex_op, 3);
    chk("sub_reg_write", rw_n, 1);
    instr(OP_LW, 1'b0);
    chk("lw_latency", lat, 5);
    chk("lw_mem_read_ior", mrio_n, 1);
    chk("lw_mem_to_reg", m2r_n, 1);
    instr(OP_SW, 1'b0);
    chk("sw_latency", lat, 4);
    chk("sw_mem_write_once", mw_n, 1);
    instr(OP_BEQ, 1'b1);
    chk("beq_taken_latency", lat, 3);
    chk("beq_taken_pc_en", pe_x, 1);
    instr(OP_BEQ, 1'b0);
    chk("beq_not_taken_latency", lat, 3);
    chk("beq_not_taken_pc_en", pe_x, 0);
    instr(4'b0111, 1'b1);
    chk("illegal_latency", lat, 2);
    chk("illegal_enables", rw_n + mw_n + pe_x, 0);
    instr(OP_J, 1'b0);
    chk("jump_latency", lat, 3);
    chk("jump_pc_en", pe_x, 1);
    instr(4'b0000, 1'b0);
    chk("mov_exec_alu_op", ex_op, 0);
    opcode = OP_HALT;
    repeat (8) @(posedge clk);
    #1;
    chk("halt_halted", int'(halted), 1);
    chk("halt_state", int'(state), int'(S_HALT));
    chk("halt_pc_en", int'(pc_en), 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("halt_reset_fetch", int'(state), int'(S_FETCH));
    opcode = OP_SW;
    for (int i = 0; i < 10 && state != 4'(S_MEM_WRITE); i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_mem_write", int'(state), int'(S_MEM_WRITE));
    reset = 1'b1;
    #1 chk("abort_mem_write", int'(mem_write), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("abort_fetch", int'(state), int'(S_FETCH));
    opcode = 4'b1100;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
